// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / RAW hazard detection, branch flush and operand
// forwarding control for a 5-stage in-order pipeline.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   -> EX/MEM and WB forwarding; only load-use stalls.
//   undefined -> no forwarding (fwd_a/fwd_b tied to 00); any RAW
//                dependency on EX or MEM stalls. WB writes the register
//                file before ID reads it, so WB never stalls.
//
// The controller tracks a small shadow of the pipeline (EX, MEM, WB), each
// holding {valid, we, load, dest}, and derives hazards from it.

`default_nettype none

module hazard_ctrl #(
    parameter int data_width = 32,
    parameter int cnt_width  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rt,
    input  logic                 id_use_imm,
    input  logic                 id_we,
    input  logic                 id_load,
    input  logic [4:0]           id_dest,
    input  logic                 ex_branch_taken,
    output logic                 stall,
    output logic                 flush,
    output logic                 alu_src_sel,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [cnt_width-1:0] stall_cnt
);

    // Operand width only documents the datapath this controller steers.
    if (data_width > 0) begin : g_datapath_width
    end

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       load;
        logic [4:0] dest;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

`ifdef HAZARD_FORWARD_EN
    // With forwarding only a load sitting in EX is too late to bypass.
    localparam logic WIN_MEM = 1'b0;
`else
    // Without forwarding both EX and MEM producers are still in flight.
    localparam logic WIN_MEM = 1'b1;
`endif
    // WB writes the register file in the first half cycle: never a hazard.
    localparam logic WIN_WB = 1'b0;

    shadow_t ex_r, mem_r, wb_r;
    shadow_t ex_next_s;
    state_t  state_r, state_next_s;

    logic                 stall_s;
    logic                 flush_s;
    logic                 issue_s;
    logic                 win_ex_s;
    logic                 rs_hit_s;
    logic                 rt_hit_s;
    logic                 alu_src_r;
    logic [cnt_width-1:0] stall_cnt_r;

    // A shadow entry produces r if it is a live write to a non-zero register.
    function automatic logic match_f(input shadow_t e, input logic [4:0] r);
        return e.valid & e.we & (e.dest != 5'd0) & (e.dest == r);
    endfunction

    // Match gated by whether that stage still belongs to the hazard window.
    function automatic logic hazard_on(input shadow_t e, input logic [4:0] r,
                                       input logic in_window);
        return in_window & match_f(e, r);
    endfunction

    // Hazard detection: stall/flush are combinational, flush wins over stall.
    always_comb begin
        flush_s  = ex_branch_taken;
`ifdef HAZARD_FORWARD_EN
        win_ex_s = ex_r.load;
`else
        win_ex_s = 1'b1;
`endif
        rs_hit_s = hazard_on(ex_r,  id_rs, win_ex_s) |
                   hazard_on(mem_r, id_rs, WIN_MEM)  |
                   hazard_on(wb_r,  id_rs, WIN_WB);
        rt_hit_s = hazard_on(ex_r,  id_rt, win_ex_s) |
                   hazard_on(mem_r, id_rt, WIN_MEM)  |
                   hazard_on(wb_r,  id_rt, WIN_WB);
        if (flush_s) begin
            stall_s = 1'b0;
        end else begin
            stall_s = id_valid & (rs_hit_s | (id_uses_rt & rt_hit_s));
        end
        issue_s = id_valid & ~stall_s & ~flush_s;
    end

    assign stall = stall_s;
    assign flush = flush_s;

    // Next EX entry: the decoded instruction on issue, otherwise a bubble.
    always_comb begin
        ex_next_s = '0;
        if (issue_s) begin
            ex_next_s.valid = 1'b1;
            ex_next_s.we    = id_we;
            ex_next_s.load  = id_load;
            ex_next_s.dest  = id_dest;
        end else begin
            ex_next_s = '0;
        end
    end

    // Shadow pipeline advances every cycle: WB <= MEM <= EX <= ID/bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Next-state: records why the upcoming EX slot holds a bubble.
    always_comb begin
        state_next_s = ST_RUN;
        case (state_r)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (flush_s) begin
                    state_next_s = ST_FLUSH;
                end else if (stall_s) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Bubble-cause state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating count of cycles whose bubble was caused by a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if ((state_next_s == ST_STALL) && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

    // Operand-B source select follows the issuing instruction; bubbles get 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src_r <= 1'b0;
        end else if (issue_s) begin
            alu_src_r <= id_use_imm;
        end else begin
            alu_src_r <= 1'b0;
        end
    end

    assign alu_src_sel = alu_src_r;

`ifdef HAZARD_FORWARD_EN
    logic [1:0] fwd_a_next_s, fwd_b_next_s;
    logic [1:0] fwd_a_r, fwd_b_r;

    // Forward select: current EX becomes EX/MEM (10), current MEM becomes WB (01).
    always_comb begin
        fwd_a_next_s = 2'b00;
        fwd_b_next_s = 2'b00;
        if (match_f(ex_r, id_rs)) begin
            fwd_a_next_s = 2'b10;
        end else if (match_f(mem_r, id_rs)) begin
            fwd_a_next_s = 2'b01;
        end else begin
            fwd_a_next_s = 2'b00;
        end
        if (!id_uses_rt || id_use_imm) begin
            fwd_b_next_s = 2'b00;
        end else if (match_f(ex_r, id_rt)) begin
            fwd_b_next_s = 2'b10;
        end else if (match_f(mem_r, id_rt)) begin
            fwd_b_next_s = 2'b01;
        end else begin
            fwd_b_next_s = 2'b00;
        end
    end

    // Forward selects are captured on issue; a bubble clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_r <= 2'b00;
            fwd_b_r <= 2'b00;
        end else if (issue_s) begin
            fwd_a_r <= fwd_a_next_s;
            fwd_b_r <= fwd_b_next_s;
        end else begin
            fwd_a_r <= 2'b00;
            fwd_b_r <= 2'b00;
        end
    end

    assign fwd_a = fwd_a_r;
    assign fwd_b = fwd_b_r;
`else
    // No bypass network: operands always come from the register file.
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed
// by random traffic, compared against an issue-history reference model.
// Works for both builds (HAZARD_FORWARD_EN defined or not).

`timescale 1ns/1ps

module tb_hazard_ctrl;

    localparam int CW = 4;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rt, id_use_imm, id_we, id_load;
    logic [4:0]    id_rs, id_rt, id_dest;
    logic          ex_branch_taken;
    logic          stall, flush, alu_src_sel;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.data_width(32), .cnt_width(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_use_imm(id_use_imm),
        .id_we(id_we), .id_load(id_load), .id_dest(id_dest),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush(flush), .alu_src_sel(alu_src_sel),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid; int rs; int rt; bit uses_rt; bit use_imm;
        bit we; bit load; int dest; bit br;
    } instr_t;

    // One record per cycle of what entered EX; index 0 = most recent.
    typedef struct { bit live; bit writes; bit is_load; int dest; } rec_t;

    rec_t hist[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_alu, exp_fa, exp_fb, exp_cnt;
    bit   last_stall;
    int   snap;

    function automatic instr_t mk(bit v, int rs, int rt, bit urt, bit imm,
                                  bit we, bit ld, int dest, bit br);
        instr_t s;
        s.valid = v; s.rs = rs; s.rt = rt; s.uses_rt = urt; s.use_imm = imm;
        s.we = we; s.load = ld; s.dest = dest; s.br = br;
        return s;
    endfunction

    function automatic bit hits(int ago, int r);
        return hist[ago].live && hist[ago].writes && hist[ago].dest != 0 &&
               hist[ago].dest == r;
    endfunction

    function automatic int src_sel(int r);
        if (hits(0, r)) return 2;
        if (hits(1, r)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        rec_t e;
        e = '{live: 1'b0, writes: 1'b0, is_load: 1'b0, dest: 0};
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(e);
        exp_alu = 0; exp_fa = 0; exp_fb = 0; exp_cnt = 0; last_stall = 1'b0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_regs(string tag);
        chk({tag, " alu_src_sel"}, 32'(alu_src_sel), exp_alu);
        chk({tag, " fwd_a"}, 32'(fwd_a), exp_fa);
        chk({tag, " fwd_b"}, 32'(fwd_b), exp_fb);
        chk({tag, " stall_cnt"}, 32'(stall_cnt), exp_cnt);
    endtask

    task automatic drive(instr_t s);
        id_valid = s.valid; id_rs = 5'(s.rs); id_rt = 5'(s.rt);
        id_uses_rt = s.uses_rt; id_use_imm = s.use_imm;
        id_we = s.we; id_load = s.load; id_dest = 5'(s.dest);
        ex_branch_taken = s.br;
    endtask

    // Drive one ID-stage instruction for one cycle and check everything.
    task automatic run_cycle(string tag, instr_t s);
        bit   st, iss;
        rec_t e;
        drive(s);
        #3;
        if (FWD)
            st = s.valid && hist[0].is_load && hist[0].live &&
                 (hits(0, s.rs) || (s.uses_rt && hits(0, s.rt)));
        else
            st = s.valid && (hits(0, s.rs) || hits(1, s.rs) ||
                 (s.uses_rt && (hits(0, s.rt) || hits(1, s.rt))));
        if (s.br) st = 1'b0;
        chk({tag, " stall"}, 32'(stall), 32'(st));
        chk({tag, " flush"}, 32'(flush), 32'(s.br));
        iss = s.valid && !st && !s.br;
        exp_alu = (iss && s.use_imm) ? 1 : 0;
        exp_fa  = (FWD && iss) ? src_sel(s.rs) : 0;
        exp_fb  = (FWD && iss && s.uses_rt && !s.use_imm) ? src_sel(s.rt) : 0;
        if (st && exp_cnt < (1 << CW) - 1) exp_cnt++;
        e.live = iss; e.writes = iss && s.we; e.is_load = iss && s.load;
        e.dest = iss ? s.dest : 0;
        hist.push_front(e);
        void'(hist.pop_back());
        last_stall = st;
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    // Hold an instruction in ID until it issues (bounded).
    task automatic issue(string tag, instr_t s);
        int n = 0;
        do begin
            run_cycle(tag, s);
            n++;
        end while (last_stall && n < 6);
        chk({tag, " issued within bound"}, 32'(stall), 32'd0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) run_cycle("idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        instr_t s;
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        check_regs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw r5 ; add r6,r5,r7 -> load-use stall then WB forward
        snap = exp_cnt;
        run_cycle("lu lw", mk(1, 1, 0, 0, 1, 1, 1, 5, 0));
        issue("lu add", mk(1, 5, 7, 1, 0, 1, 0, 6, 0));
        chk("lu fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
        chk("lu stall count", 32'(stall_cnt), 32'(snap + (FWD ? 1 : 2)));
        idle(3);

        // add r3 ; sub r4,r3,r3 -> EX/MEM forward both operands
        snap = exp_cnt;
        run_cycle("raw add", mk(1, 1, 2, 1, 0, 1, 0, 3, 0));
        issue("raw sub", mk(1, 3, 3, 1, 0, 1, 0, 4, 0));
        chk("raw fwd_a", 32'(fwd_a), FWD ? 32'd2 : 32'd0);
        chk("raw fwd_b", 32'(fwd_b), FWD ? 32'd2 : 32'd0);
        chk("raw stall count", 32'(stall_cnt), 32'(snap + (FWD ? 0 : 2)));
        idle(3);

        // add r3 ; addi with rt=r3 and immediate operand B
        run_cycle("imm add", mk(1, 1, 2, 1, 0, 1, 0, 3, 0));
        issue("imm addi", mk(1, 1, 3, 1, 1, 1, 0, 4, 0));
        chk("imm alu_src_sel", 32'(alu_src_sel), 32'd1);
        chk("imm fwd_b", 32'(fwd_b), 32'd0);
        idle(3);

        // branch together with load-use -> flush only, counter unchanged
        run_cycle("br lw", mk(1, 1, 0, 0, 1, 1, 1, 5, 0));
        snap = exp_cnt;
        run_cycle("br use", mk(1, 5, 5, 1, 0, 1, 0, 6, 1));
        chk("br stall count", 32'(stall_cnt), 32'(snap));
        idle(3);

        // write to r0 then read r0 -> no hazard ever
        run_cycle("r0 write", mk(1, 1, 2, 1, 0, 1, 1, 0, 0));
        run_cycle("r0 read", mk(1, 0, 0, 1, 0, 1, 0, 4, 0));
        chk("r0 fwd_a", 32'(fwd_a), 32'd0);
        idle(3);

        // reset asserted in the middle of a stall
        run_cycle("mr lw", mk(1, 1, 0, 0, 1, 1, 1, 8, 0));
        drive(mk(1, 8, 0, 0, 0, 1, 0, 9, 0));
        #2;
        chk("mr stall before reset", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mr stall in reset", 32'(stall), 32'd0);
        check_regs("mr in reset");
        @(posedge clk);
        #1;
        check_regs("mr held");
        rst_n = 1'b1;
        run_cycle("mr after release", mk(1, 8, 0, 0, 0, 1, 0, 9, 0));
        idle(2);

        // counter saturation at all-ones
        for (int i = 0; i < 17; i++) begin
            run_cycle("sat lw", mk(1, 1, 0, 0, 1, 1, 1, 2, 0));
            issue("sat use", mk(1, 2, 0, 0, 0, 1, 0, 6, 0));
        end
        chk("sat stall_cnt", 32'(stall_cnt), 32'((1 << CW) - 1));

        // random traffic on a small register set to provoke hazards
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            s = mk($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) != 0, $urandom_range(0, 4) < 2,
                   $urandom_range(0, 3), $urandom_range(0, 9) == 0);
            run_cycle("rand", s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
